// File: rtl/usb_crc.sv
// Serial USB CRC inserter. Packet bits (SYNC+PID+payload) pass through a bit FIFO;
// CRC5 (token) or CRC16 (data) is computed over the bits after SYNC+PID and the
// complemented CRC is appended MSB-first on the output stream.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start, pkt_type     packet start pulse and type (00 hs, 01 token, 10 data, 11 no-CRC)
//   s_in, endr          serial input bit and last-bit marker
//   pause               downstream stall, freezes the output side
//   start_b, s_out      output start pulse and serial output bit
//   endr_b              marks the last output bit

// Output sequencer: emits start_b, drains the FIFO, then shifts out the CRC.
module usb_crc_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        pause,
  input  logic        empty,
  input  logic        last,
  input  logic        has_crc,
  input  logic        token,
  input  logic        fifo_bit,
  input  logic [15:0] crc_tx,
  output logic        idle_c,
  output logic        pop_c,
  output logic        start_b,
  output logic        s_out,
  output logic        endr_b
);

  typedef enum logic [2:0] {IDLE, START, SEND, CRC, DONE} state_t;

  state_t      cs;
  state_t      ns;
  logic [15:0] crc_sr;
  logic [3:0]  crc_cnt;

  assign idle_c = (cs == IDLE);
  assign pop_c  = (cs == SEND) && !pause && !empty;

  // Next-state logic; every transition out of a busy state waits for an unpaused cycle.
  always_comb begin
    ns = cs;
    case (cs)
      IDLE:    if (start) ns = START;
      START:   if (!pause) ns = SEND;
      SEND:    if (pop_c && last) ns = has_crc ? CRC : DONE;
      CRC:     if (!pause && (crc_cnt == 4'd0)) ns = DONE;
      DONE:    if (!pause) ns = IDLE;
      default: ns = IDLE;
    endcase
  end

  // State and registered outputs; s_out holds whenever nothing is shifted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs      <= IDLE;
      start_b <= 1'b0;
      s_out   <= 1'b0;
      endr_b  <= 1'b0;
      crc_sr  <= 16'd0;
      crc_cnt <= 4'd0;
    end else begin
      cs      <= ns;
      start_b <= (cs == START) && !pause;
      endr_b  <= (pop_c && last && !has_crc) ||
                 ((cs == CRC) && !pause && (crc_cnt == 4'd0));
      if (pop_c) begin
        s_out <= fifo_bit;
        // CRC is already frozen by the time the last packet bit leaves the FIFO.
        if (last) begin
          crc_sr  <= crc_tx;
          crc_cnt <= token ? 4'd4 : 4'd15;
        end
      end else if ((cs == CRC) && !pause) begin
        s_out   <= crc_sr[15];
        crc_sr  <= {crc_sr[14:0], 1'b0};
        crc_cnt <= crc_cnt - 4'd1;
      end
    end
  end

endmodule

module usb_crc #(
  parameter int unsigned FIFO_DEPTH = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [1:0] pkt_type,
  input  logic       s_in,
  input  logic       endr,
  input  logic       pause,
  output logic       start_b,
  output logic       s_out,
  output logic       endr_b
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [1:0]  PT_TOKEN = 2'b01;
  localparam logic [1:0]  PT_DATA  = 2'b10;

  logic                  idle;
  logic                  accept;
  logic                  rx_active;
  logic                  rx_end;
  logic                  endr_seen;
  logic                  crc_pend;
  logic [1:0]            ptype;
  logic [4:0]            bit_cnt;
  logic                  feed;
  logic                  token;
  logic [4:0]            crc5;
  logic [15:0]           crc16;
  logic [15:0]           crc_tx;
  logic                  crc5_start;
  logic                  crc5_ready;
  logic                  crc5_done;
  logic                  crc16_start;
  logic                  crc16_ready;
  logic                  crc16_done;
  logic                  fb5;
  logic                  fb16;
  logic [FIFO_DEPTH-1:0] mem;
  logic [AW-1:0]         wp;
  logic [AW-1:0]         rp;
  logic [CW-1:0]         count;
  logic                  empty;
  logic                  full;
  logic                  wr;
  logic                  rd;
  logic                  last;
  logic                  fifo_bit;

  assign accept      = start && idle;
  assign rx_end      = rx_active && endr;
  // Bit counter saturates at 16: from then on every bit is payload.
  assign feed        = rx_active && (bit_cnt == 5'd16);
  assign token       = (ptype == PT_TOKEN);
  assign crc5_start  = accept && (pkt_type == PT_TOKEN);
  assign crc16_start = accept && (pkt_type == PT_DATA);
  assign crc5_ready  = feed && token;
  assign crc16_ready = feed && (ptype == PT_DATA);
  assign crc5_done   = rx_end && token;
  assign crc16_done  = rx_end && (ptype == PT_DATA);
  assign fb5         = s_in ^ crc5[4];
  assign fb16        = s_in ^ crc16[15];
  assign crc_tx      = token ? {~crc5, 11'd0} : ~crc16;

  assign empty    = (count == CW'(0));
  assign full     = (count == CW'(FIFO_DEPTH));
  assign wr       = rx_active && !full;
  assign last     = endr_seen && (count == CW'(1));
  assign fifo_bit = mem[rp];

  // Input side: capture window, bit counter and CRC engines; never paused.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_active <= 1'b0;
      endr_seen <= 1'b0;
      crc_pend  <= 1'b0;
      ptype     <= 2'b00;
      bit_cnt   <= 5'd0;
      crc5      <= 5'h1f;
      crc16     <= 16'hffff;
    end else begin
      if (accept) begin
        rx_active <= 1'b1;
        endr_seen <= 1'b0;
        crc_pend  <= 1'b0;
        ptype     <= pkt_type;
        bit_cnt   <= 5'd0;
      end else if (rx_active) begin
        if (bit_cnt != 5'd16) bit_cnt <= bit_cnt + 5'd1;
        if (endr) begin
          rx_active <= 1'b0;
          endr_seen <= 1'b1;
        end
        if (crc5_done || crc16_done) crc_pend <= 1'b1;
      end
      if (crc5_start)      crc5 <= 5'h1f;
      else if (crc5_ready) crc5 <= {crc5[3:0], 1'b0} ^ (fb5 ? 5'b00101 : 5'b00000);
      if (crc16_start)      crc16 <= 16'hffff;
      else if (crc16_ready) crc16 <= {crc16[14:0], 1'b0} ^ (fb16 ? 16'h8005 : 16'h0000);
    end
  end

  // Bit FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (wr) wp <= wp + AW'(1);
      if (rd) rp <= rp + AW'(1);
      if (wr && !rd)      count <= count + CW'(1);
      else if (!wr && rd) count <= count - CW'(1);
    end
  end

  // FIFO storage needs no reset; occupancy alone defines validity.
  always_ff @(posedge clk) begin
    if (wr) mem[wp] <= s_in;
  end

  usb_crc_ctrl ctrl (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .pause    (pause),
    .empty    (empty),
    .last     (last),
    .has_crc  (crc_pend),
    .token    (token),
    .fifo_bit (fifo_bit),
    .crc_tx   (crc_tx),
    .idle_c   (idle),
    .pop_c    (rd),
    .start_b  (start_b),
    .s_out    (s_out),
    .endr_b   (endr_b)
  );

endmodule

// File: tb/tb_usb_crc.sv
// Scoreboard bench for usb_crc: the driver queues expected start cycles, output bits
// and last-bit cycles; a negedge monitor pops and compares as the DUT presents them.
module tb_usb_crc;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [1:0] pkt_type;
  logic       s_in;
  logic       endr;
  logic       pause;
  logic       start_b;
  logic       s_out;
  logic       endr_b;

  typedef struct packed {
    logic b;
    logic last;
  } exp_t;

  exp_t exp_q[$];
  int   exp_sb[$];
  int   exp_end[$];

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic adv = 1'b0;
  logic in_pkt = 1'b0;
  logic mon_en = 1'b0;
  logic last_s = 1'b0;

  localparam logic [31:0] TOK  = 32'(27'b000000011000000100001000111);
  localparam logic [31:0] HS   = 32'(16'b0000000101001011);
  localparam logic [31:0] DAT0 = 32'(16'b0000000111000011);

  usb_crc dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .pkt_type (pkt_type),
    .s_in     (s_in),
    .endr     (endr),
    .pause    (pause),
    .start_b  (start_b),
    .s_out    (s_out),
    .endr_b   (endr_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h want %0h", name, cyc, got, want);
    end
  endtask

  // Cycle index and whether the edge just taken advanced the output side.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    adv <= ~pause;
  end

  always @(negedge clk) begin
    exp_t e;
    int   t;
    if (mon_en) begin
      if (start_b) begin
        if (exp_sb.size() == 0) begin
          chk("unexpected_start_b", 32'(exp_sb.size()), 32'd1);
        end else begin
          t = exp_sb.pop_front();
          chk("start_b_cycle", 32'(cyc), 32'(t));
        end
        chk("start_b_while_busy", 32'(in_pkt), 32'd0);
        in_pkt = 1'b1;
        last_s = s_out;
      end else if (in_pkt && adv) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_bit", 32'(exp_q.size()), 32'd1);
          in_pkt = 1'b0;
        end else begin
          e = exp_q.pop_front();
          chk("s_out_bit", 32'(s_out), 32'(e.b));
          chk("endr_b_flag", 32'(endr_b), 32'(e.last));
          if (e.last) begin
            if (exp_end.size() != 0) begin
              t = exp_end.pop_front();
              chk("endr_b_cycle", 32'(cyc), 32'(t));
            end
            in_pkt = 1'b0;
          end
        end
        last_s = s_out;
      end else if (in_pkt) begin
        chk("paused_hold", {30'd0, s_out, endr_b}, {30'd0, last_s, 1'b0});
      end else begin
        chk("idle_endr_b", 32'(endr_b), 32'd0);
      end
    end
  end

  task automatic send_pkt(input logic [1:0] pt, input logic [31:0] vec, input int n,
                          input logic [15:0] crc, input int ncrc,
                          input int pause_at, input int pause_len, input int restart_at);
    int t0;
    int i;
    @(posedge clk); #1;
    start    = 1'b1;
    pkt_type = pt;
    t0       = cyc;
    exp_sb.push_back(t0 + 2);
    for (int k = 0; k < n; k++) exp_q.push_back('{vec[n-1-k], (ncrc == 0) && (k == n-1)});
    for (int j = 0; j < ncrc; j++) exp_q.push_back('{crc[ncrc-1-j], j == ncrc-1});
    exp_end.push_back(t0 + 2 + n + ncrc + pause_len);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      start    = (k == restart_at);
      pkt_type = (k == restart_at) ? 2'b00 : pt;
      s_in     = vec[n-1-k];
      endr     = (k == n-1);
      pause    = (k >= pause_at) && (k < pause_at + pause_len);
    end
    @(posedge clk); #1;
    start = 1'b0;
    s_in  = 1'b0;
    endr  = 1'b0;
    pause = 1'b0;
    i = 0;
    while (i < 200 && !(exp_q.size() == 0 && !in_pkt)) begin
      @(posedge clk);
      i++;
    end
    chk("packet_drained", {31'd0, in_pkt} | 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    exp_sb.delete();
    exp_end.delete();
    in_pkt = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_outputs"}, {29'd0, start_b, s_out, endr_b}, 32'd0);
    chk({tag, "_empty"}, 32'(dut.empty), 32'd1);
    chk({tag, "_idle"}, 32'(dut.idle), 32'd1);
    chk({tag, "_crc5"}, 32'(dut.crc5), 32'h1f);
  endtask

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    pkt_type = 2'b00;
    s_in     = 1'b0;
    endr     = 1'b0;
    pause    = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk_reset_state("por");
    mon_en = 1'b1;

    // Token, CRC5 10100 appended.
    send_pkt(2'b01, TOK, 27, 16'h0014, 5, 100, 0, -1);
    // Handshake: echo only.
    send_pkt(2'b00, HS, 16, 16'h0000, 0, 100, 0, -1);
    // Zero-length data: CRC16 of nothing complements to all zeros.
    send_pkt(2'b10, DAT0, 16, 16'h0000, 16, 100, 0, -1);
    // Token with a 5-cycle pause mid-payload.
    send_pkt(2'b01, TOK, 27, 16'h0014, 5, 18, 5, -1);
    // Token with a second start during SEND.
    send_pkt(2'b01, TOK, 27, 16'h0014, 5, 100, 0, 10);

    // Abort a token after bit 10 with reset.
    mon_en = 1'b0;
    @(posedge clk); #1;
    start    = 1'b1;
    pkt_type = 2'b01;
    for (int k = 0; k <= 10; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
      s_in  = TOK[26-k];
    end
    @(posedge clk); #1;
    s_in  = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    chk_reset_state("abort");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    exp_q.delete();
    exp_sb.delete();
    exp_end.delete();
    in_pkt = 1'b0;
    @(negedge clk);
    chk_reset_state("post_abort");
    mon_en = 1'b1;
    send_pkt(2'b01, TOK, 27, 16'h0014, 5, 100, 0, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
